// File: rtl/register_write_arbiter_if.sv
// Write-port bundle between NUM_REQ producers and the shared register arbiter.
// The master side drives requests/data; the slave side returns grants and register state.
interface register_write_arbiter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         out;
    logic [IDX_W-1:0]         owner;
    logic                     wr_pulse;
    logic                     busy;

    modport master (
        output req, wdata,
        input  gnt, out, owner, wr_pulse, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, out, owner, wr_pulse, busy
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter loading one shared register from NUM_REQ write ports,
// with an optional quiet window of MIN_GAP cycles after every write.
module register_write_arbiter #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      NUM_REQ     = 4,
    parameter int unsigned      MIN_GAP     = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    register_write_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP != 0) ? GAP_W'(MIN_GAP - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_nxt;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic [NUM_REQ-1:0] gnt_c;

    logic [WIDTH-1:0] out_q;
    logic [IDX_W-1:0] owner_q;
    logic             wr_pulse_q;

    logic [WIDTH-1:0] lane [NUM_REQ];

    // Unpack the flat write-data bus into per-requester lanes.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = bus.wdata[g*WIDTH +: WIDTH];
    end

    // Rotating priority search starting at ptr; only req and registered state feed the grant.
    always_comb begin
        gnt_c   = '0;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        if (!rst && state == IDLE) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
                if (!win_vld && bus.req[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
            gnt_c[win_idx] = win_vld;
        end
    end

    assign ptr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);

    // Next-state: a write opens the quiet window; the counter drains it back to IDLE.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        unique case (state)
            IDLE: begin
                if (win_vld && MIN_GAP != 0) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                gap_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Shared register, last writer and rotation pointer advance only on a write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= RESET_VALUE;
            owner_q    <= '0;
            wr_pulse_q <= 1'b0;
            ptr        <= '0;
        end else begin
            wr_pulse_q <= win_vld;
            if (win_vld) begin
                out_q   <= lane[win_idx];
                owner_q <= win_idx;
                ptr     <= ptr_nxt;
            end
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.out      = out_q;
    assign bus.owner    = owner_q;
    assign bus.wr_pulse = wr_pulse_q;
    assign bus.busy     = (state == GAP);

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: three instances (MIN_GAP 0, 3, 5) exercised with
// a vector table, hand sequences for the gap/reset corners, and random traffic vs a model.
module tb_register_write_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic clk;
    logic rst0, rst3, rst5;

    register_write_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) if0 ();
    register_write_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) if3 ();
    register_write_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) if5 ();

    register_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MIN_GAP(0), .RESET_VALUE(RV))
        dut0 (.clk(clk), .rst(rst0), .bus(if0));
    register_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MIN_GAP(3), .RESET_VALUE(RV))
        dut3 (.clk(clk), .rst(rst3), .bus(if3));
    register_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MIN_GAP(5), .RESET_VALUE(RV))
        dut5 (.clk(clk), .rst(rst5), .bus(if5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] d0, input logic [31:0] d1,
                                           input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Reference arbitration: first asserted requester scanning from ptr with wrap.
    function automatic int pick(input int ptr, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0]   req;
        logic [127:0] wdata;
        logic [3:0]   gnt;
        logic [31:0]  out;
        logic [1:0]   owner;
        logic         wr;
    } vec_t;

    vec_t         tbl [16];
    logic [127:0] wd_a;
    logic [127:0] wd_b;
    logic [3:0]   gap_gnt  [9];
    logic         gap_busy [9];

    int           m_ptr [2];
    int           m_gap [2];
    int           m_own [2];
    logic [31:0]  m_out [2];
    logic         m_wr  [2];
    int           gaps  [2];
    logic [3:0]   r_req [2];
    logic [127:0] r_wd  [2];

    logic [3:0]  a_gnt;
    logic [31:0] a_out;
    logic [1:0]  a_own;
    logic        a_wr;
    logic        a_busy;
    logic [3:0]  e_gnt;
    int          w;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst0 = 1'b0; rst3 = 1'b0; rst5 = 1'b0;
        if0.req = 4'b1111; if3.req = 4'b1111; if5.req = 4'b1111;
        if0.wdata = '0; if3.wdata = '0; if5.wdata = '0;

        wd_a = pack4(32'd1, 32'd2, 32'd3, 32'd4);
        wd_b = pack4(32'd1, 32'd2, 32'h1234_5678, 32'd4);

        tbl[0]  = '{4'b1111, wd_a, 4'b0001, RV,           2'd0, 1'b0};
        tbl[1]  = '{4'b1111, wd_a, 4'b0010, 32'd1,        2'd0, 1'b1};
        tbl[2]  = '{4'b1111, wd_a, 4'b0100, 32'd2,        2'd1, 1'b1};
        tbl[3]  = '{4'b1111, wd_a, 4'b1000, 32'd3,        2'd2, 1'b1};
        tbl[4]  = '{4'b1111, wd_a, 4'b0001, 32'd4,        2'd3, 1'b1};
        tbl[5]  = '{4'b0100, wd_b, 4'b0100, 32'd1,        2'd0, 1'b1};
        tbl[6]  = '{4'b0000, wd_a, 4'b0000, 32'h1234_5678, 2'd2, 1'b1};
        tbl[7]  = '{4'b0000, wd_a, 4'b0000, 32'h1234_5678, 2'd2, 1'b0};
        tbl[8]  = '{4'b1000, wd_a, 4'b1000, 32'h1234_5678, 2'd2, 1'b0};
        tbl[9]  = '{4'b0101, wd_a, 4'b0001, 32'd4,        2'd3, 1'b1};
        tbl[10] = '{4'b0101, wd_a, 4'b0100, 32'd1,        2'd0, 1'b1};
        tbl[11] = '{4'b0011, wd_a, 4'b0001, 32'd3,        2'd2, 1'b1};
        tbl[12] = '{4'b0011, wd_a, 4'b0010, 32'd1,        2'd0, 1'b1};
        tbl[13] = '{4'b0000, wd_a, 4'b0000, 32'd2,        2'd1, 1'b1};
        tbl[14] = '{4'b0010, wd_a, 4'b0010, 32'd2,        2'd1, 1'b0};
        tbl[15] = '{4'b0010, wd_a, 4'b0010, 32'd2,        2'd1, 1'b1};

        gap_gnt  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                     4'b0000, 4'b0000, 4'b0000, 4'b0001};
        gap_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Asynchronous reset asserted between edges with requests pending.
        @(negedge clk);
        #2;
        rst0 = 1'b1; rst3 = 1'b1; rst5 = 1'b1;
        #1;
        chk("rst_gnt0",  32'(if0.gnt), 32'd0);
        chk("rst_out0",  if0.out, RV);
        chk("rst_own0",  32'(if0.owner), 32'd0);
        chk("rst_wr0",   32'(if0.wr_pulse), 32'd0);
        chk("rst_busy0", 32'(if0.busy), 32'd0);
        chk("rst_gnt3",  32'(if3.gnt), 32'd0);
        chk("rst_out3",  if3.out, RV);
        chk("rst_gnt5",  32'(if5.gnt), 32'd0);
        chk("rst_out5",  if5.out, RV);
        if3.req = '0; if5.req = '0;

        @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0; rst5 = 1'b0;

        // Table: round robin, single write, withdraw, pointer skip/wrap, single requester.
        for (int i = 0; i < 16; i++) begin
            if0.req   = tbl[i].req;
            if0.wdata = tbl[i].wdata;
            #1;
            chk($sformatf("tbl%0d_gnt", i),  32'(if0.gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_out", i),  if0.out, tbl[i].out);
            chk($sformatf("tbl%0d_own", i),  32'(if0.owner), 32'(tbl[i].owner));
            chk($sformatf("tbl%0d_wr", i),   32'(if0.wr_pulse), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_busy", i), 32'(if0.busy), 32'd0);
            @(negedge clk);
        end
        if0.req = '0;

        // Gap window: MIN_GAP=3 with two requesters held.
        if3.req   = 4'b0011;
        if3.wdata = wd_a;
        for (int c = 0; c < 9; c++) begin
            #1;
            chk($sformatf("gap%0d_gnt", c),  32'(if3.gnt), 32'(gap_gnt[c]));
            chk($sformatf("gap%0d_busy", c), 32'(if3.busy), 32'(gap_busy[c]));
            if (c == 1) begin
                chk("gap_out_a", if3.out, 32'd1);
                chk("gap_wr_a",  32'(if3.wr_pulse), 32'd1);
            end
            if (c == 2) chk("gap_wr_b", 32'(if3.wr_pulse), 32'd0);
            if (c == 5) begin
                chk("gap_out_b", if3.out, 32'd2);
                chk("gap_own_b", 32'(if3.owner), 32'd1);
            end
            @(negedge clk);
        end
        if3.req = '0;

        // Reset in the middle of a MIN_GAP=5 window, released with requester 3 pending.
        if5.req   = 4'b0001;
        if5.wdata = wd_a;
        #1;
        chk("mg_gnt_first", 32'(if5.gnt), 32'd1);
        @(negedge clk);
        if5.req = '0;
        #1;
        chk("mg_busy", 32'(if5.busy), 32'd1);
        chk("mg_out",  if5.out, 32'd1);
        @(negedge clk);
        #2;
        rst5    = 1'b1;
        if5.req = 4'b1000;
        #1;
        chk("mg_rst_out",  if5.out, RV);
        chk("mg_rst_busy", 32'(if5.busy), 32'd0);
        chk("mg_rst_gnt",  32'(if5.gnt), 32'd0);
        chk("mg_rst_own",  32'(if5.owner), 32'd0);
        @(negedge clk);
        rst5 = 1'b0;
        #1;
        chk("mg_rel_gnt",  32'(if5.gnt), 32'b1000);
        chk("mg_rel_busy", 32'(if5.busy), 32'd0);
        chk("mg_rel_out",  if5.out, RV);
        @(negedge clk);
        if5.req = '0;
        #1;
        chk("mg_post_out",  if5.out, 32'd4);
        chk("mg_post_own",  32'(if5.owner), 32'd3);
        chk("mg_post_wr",   32'(if5.wr_pulse), 32'd1);
        chk("mg_post_busy", 32'(if5.busy), 32'd1);

        // Random traffic on MIN_GAP=0 and MIN_GAP=3 instances against the reference model.
        @(negedge clk);
        rst0 = 1'b1; rst3 = 1'b1;
        if0.req = '0; if3.req = '0;
        @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;
        gaps = '{0, 3};
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_gap[d] = 0; m_own[d] = 0; m_out[d] = RV; m_wr[d] = 1'b0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                r_req[d] = 4'($urandom_range(0, 15));
                r_wd[d]  = {$urandom, $urandom, $urandom, $urandom};
            end
            if0.req = r_req[0]; if0.wdata = r_wd[0];
            if3.req = r_req[1]; if3.wdata = r_wd[1];
            #1;
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    a_gnt = if0.gnt; a_out = if0.out; a_own = if0.owner;
                    a_wr = if0.wr_pulse; a_busy = if0.busy;
                end else begin
                    a_gnt = if3.gnt; a_out = if3.out; a_own = if3.owner;
                    a_wr = if3.wr_pulse; a_busy = if3.busy;
                end
                w     = (m_gap[d] == 0) ? pick(m_ptr[d], r_req[d]) : -1;
                e_gnt = (w >= 0) ? 4'(1 << w) : 4'b0000;
                chk($sformatf("rnd%0d_d%0d_gnt", cyc, d),  32'(a_gnt), 32'(e_gnt));
                chk($sformatf("rnd%0d_d%0d_out", cyc, d),  a_out, m_out[d]);
                chk($sformatf("rnd%0d_d%0d_own", cyc, d),  32'(a_own), 32'(m_own[d]));
                chk($sformatf("rnd%0d_d%0d_wr", cyc, d),   32'(a_wr), 32'(m_wr[d]));
                chk($sformatf("rnd%0d_d%0d_busy", cyc, d), 32'(a_busy), (m_gap[d] > 0) ? 32'd1 : 32'd0);
                m_wr[d] = (w >= 0);
                if (w >= 0) begin
                    m_out[d] = r_wd[d][w*32 +: 32];
                    m_own[d] = w;
                    m_ptr[d] = (w + 1) % 4;
                    m_gap[d] = gaps[d];
                end else if (m_gap[d] > 0) begin
                    m_gap[d] = m_gap[d] - 1;
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares one enabled storage register between NUM_REQ requesters. Each requester has its own write port.
- A round-robin arbiter picks one pending write per grant opportunity and loads the winner's data into the register.
- An optional post-write gap counter blocks new grants for MIN_GAP cycles after each write. This gives downstream consumers a quiet settle window.
- Sits between multiple producer blocks and a single shared configuration/status register.

Parameters:
WIDTH, 32, data width of the shared register and of each requester's data
NUM_REQ, 4, number of requesters (legal range 2..16)
MIN_GAP, 0, idle cycles forced after each write before the next grant (0..255)
RESET_VALUE, '0, value of out after reset (WIDTH bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active high
req  in  NUM_REQ  per-requester write request; bit i = requester i
wdata  in  NUM_REQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
gnt  out  NUM_REQ  combinational one-hot grant; transfer occurs on the edge where req[i]&gnt[i]
out  out  WIDTH  shared register contents
owner  out  $clog2(NUM_REQ)  index of requester that performed the last write
wr_pulse  out  1  registered; high for exactly one cycle after each write edge
busy  out  1  high while in GAP state

Behaviour:
- Reset (asynchronous, immediate on rst=1, also mid-gap or mid-transfer):
  - out=RESET_VALUE, owner=0, wr_pulse=0, busy=0.
  - Round-robin pointer=0; state=IDLE; gap counter=0.
  - gnt=0 while rst=1.
- States: IDLE, GAP.
- IDLE:
  - gnt is one-hot over the asserted req bits, or all-zero if req=0.
  - Priority search starts at the pointer p and proceeds p, p+1, ... wrapping at NUM_REQ-1 -> 0.
  - gnt depends only on req and registered state; it has no dependence on wdata.
- Write edge (IDLE and gnt[i]=1):
  - out <= wdata[i], owner <= i, wr_pulse <= 1.
  - Pointer <= (i+1) mod NUM_REQ.
  - If MIN_GAP>0: state <= GAP, counter <= MIN_GAP-1. Otherwise stay in IDLE, and back-to-back writes occur every cycle.
- No write edge: wr_pulse <= 0; out, owner and pointer hold.
- GAP:
  - gnt=0 and busy=1; req is ignored but may stay asserted.
  - Counter decrements each cycle. When the counter is 0, state <= IDLE on that edge.
  - Exactly MIN_GAP cycles have gnt=0 between consecutive write edges.
- Requester protocol:
  - The requester holds req[i] and wdata[i] stable until it sees gnt[i]=1 at a rising edge.
  - It may deassert req in the cycle after the grant.
  - If it keeps req asserted, it competes again in the next IDLE cycle at lowest priority, because the pointer has moved past it.
  - Deasserting req before grant withdraws the request with no side effect.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,...,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 grants.
- Single requester: it is granted every IDLE cycle regardless of pointer position.
- Wrap-around: pointer at NUM_REQ-1 and granted requester NUM_REQ-1 -> pointer becomes 0.
- Reset released during a pending request: arbitration begins in the first cycle with rst=0, with pointer=0.

Test Plan:
1. Reset: WIDTH=32, RESET_VALUE=32'hA5A5_0000. Assert rst asynchronously between edges -> out=A5A50000, owner=0, wr_pulse=0, gnt=0 immediately, without waiting for a clock edge.
2. Single write: MIN_GAP=0, req=4'b0100, wdata[2]=32'h1234_5678 -> gnt=4'b0100 that cycle; next cycle out=12345678, owner=2, wr_pulse=1; the following cycle (req=0) wr_pulse=0.
3. Round-robin: req=4'b1111 held, data[i]=i+1, MIN_GAP=0 -> grant order 0,1,2,3,0. out sequence 1,2,3,4,1. wr_pulse high every cycle.
4. Pointer skip/wrap: after a grant to 3, req=4'b0101 -> grant 0, then 2. After a grant to 2, req=4'b0011 -> grant 0, then 1.
5. Gap: MIN_GAP=3, req=4'b0011 held -> write edges at cycles t, t+4, t+8 (grants 0,1,0). busy=1 for exactly 3 cycles after each write and gnt=0 throughout those cycles.
6. Reset mid-gap: MIN_GAP=5, assert rst 2 cycles after a write, release 1 cycle later with req=4'b1000 -> out=RESET_VALUE during reset; busy=0; first cycle after release gnt=4'b1000, and out=data[3] on the next edge.
